// File: rtl/aes_decrypt_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes_decrypt_iter (with leaf aes_inv_sbox)
// Description : Iterative AES-128 inverse cipher. One inverse round per
//               clock, start/busy/done handshake, 11 round keys supplied on
//               a 1408-bit bus by the shared key-expansion block.
//               Optional macro AES_DEC_KEY_LATCH_EN: when defined, the round
//               key bus is captured at the start edge so the key source may
//               change while a block is in flight. When undefined, the
//               datapath reads round_keys directly on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================

// Leaf inverse S-box: a 256-entry constant table indexed by the input byte.
module aes_inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Row n of the table holds InvSbox[16n .. 16n+15], first entry leftmost.
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign out_byte = INV_SBOX[{in_byte, 3'b000} +: 8];

endmodule

module aes_decrypt_iter #(
  parameter int ROUNDS = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [0:127]                ciphertext,
  input  logic [0:128*(ROUNDS+1)-1]   round_keys,
  output logic [0:127]                plaintext,
  output logic                        busy,
  output logic                        done
);

  localparam int KEY_BITS = 128 * (ROUNDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } fsm_e;

  fsm_e         fsm_q,  fsm_d;
  logic [0:127] blk_q,  blk_d;   // working AES state
  logic [3:0]   cnt_q,  cnt_d;   // index of the round key used next
  logic [0:127] pt_q,   pt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // --------------------------------------------------------------------------
  // Round key source
  // --------------------------------------------------------------------------
  logic [0:KEY_BITS-1] key_src;

`ifdef AES_DEC_KEY_LATCH_EN
  logic [0:KEY_BITS-1] key_q, key_d;

  // Take a private copy of the whole key schedule when a block is accepted.
  always_comb begin
    key_d = key_q;
    if (fsm_q == ST_IDLE && start) begin
      key_d = round_keys;
    end
  end

  // Key copy register; holds until the next accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q <= '0;
    end else begin
      key_q <= key_d;
    end
  end

  assign key_src = key_q;
`else
  assign key_src = round_keys;
`endif

  // Split the key bus into 16 slots so a 4-bit counter can address it
  // directly; slots beyond the last round key are tied to zero.
  logic [0:127] rk_word [0:15];
  logic [0:127] rk_cur;

  for (genvar i = 0; i < 16; i++) begin : g_rk
    if (i <= ROUNDS) begin : g_used
      assign rk_word[i] = key_src[128*i +: 128];
    end else begin : g_unused
      assign rk_word[i] = '0;
    end
  end

  assign rk_cur = rk_word[cnt_q];

  // --------------------------------------------------------------------------
  // Inverse round datapath
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // One output byte of InvMixColumns: 0e*a ^ 0b*b ^ 0d*c ^ 09*d, built from
  // the x2/x4/x8 xtime chain of each operand.
  function automatic logic [7:0] inv_mix_byte(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] c,
                                              input logic [7:0] d);
    logic [7:0] a2, a4, a8, b2, b4, b8, c2, c4, c8, d2, d4, d8;
    a2 = xtime(a);  a4 = xtime(a2); a8 = xtime(a4);
    b2 = xtime(b);  b4 = xtime(b2); b8 = xtime(b4);
    c2 = xtime(c);  c4 = xtime(c2); c8 = xtime(c4);
    d2 = xtime(d);  d4 = xtime(d2); d8 = xtime(d4);
    return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
  endfunction

  logic [7:0]   isr_b [0:15];  // after InvShiftRows
  logic [7:0]   isb_b [0:15];  // after InvSubBytes
  logic [7:0]   ark_b [0:15];  // after AddRoundKey
  logic [7:0]   imc_b [0:15];  // after InvMixColumns
  logic [0:127] round_out;
  logic [0:127] final_out;

  for (genvar k = 0; k < 16; k++) begin : g_byte
    // Byte k sits at row k%4, column k/4; row r rotates right by r, so the
    // byte landing in column c comes from column (c - r) mod 4.
    localparam int R   = k % 4;
    localparam int C   = k / 4;
    localparam int SRC = R + 4 * ((C - R + 4) % 4);

    assign isr_b[k] = blk_q[8*SRC +: 8];

    aes_inv_sbox u_inv_sbox (
      .in_byte  (isr_b[k]),
      .out_byte (isb_b[k])
    );

    assign ark_b[k]              = isb_b[k] ^ rk_cur[8*k +: 8];
    assign final_out[8*k +: 8]   = ark_b[k];
    assign round_out[8*k +: 8]   = imc_b[k];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar i = 0; i < 4; i++) begin : g_row
      assign imc_b[4*c+i] = inv_mix_byte(ark_b[4*c + i],
                                         ark_b[4*c + (i+1)%4],
                                         ark_b[4*c + (i+2)%4],
                                         ark_b[4*c + (i+3)%4]);
    end
  end

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------

  // Next-state logic: load on start, nine full inverse rounds, one final.
  always_comb begin
    fsm_d  = fsm_q;
    blk_d  = blk_q;
    cnt_d  = cnt_q;
    pt_d   = pt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          blk_d  = ciphertext ^ round_keys[128*ROUNDS +: 128];
          cnt_d  = 4'(ROUNDS - 1);
          busy_d = 1'b1;
          fsm_d  = ST_ROUND;
        end
      end
      ST_ROUND: begin
        blk_d = round_out;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          fsm_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        pt_d   = final_out;
        done_d = 1'b1;
        busy_d = 1'b0;
        fsm_d  = ST_IDLE;
      end
      default: begin
        fsm_d  = ST_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any block without a done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q  <= ST_IDLE;
      blk_q  <= '0;
      cnt_q  <= '0;
      pt_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      cnt_q  <= cnt_d;
      pt_q   <= pt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign plaintext = pt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire
